datapath_ctrl: RTL and testbench
================================

Name: datapath_ctrl

Overview:
Moore FSM that sequences the 16-bit register-file/shifter/ALU datapath for one instruction at a time. It latches an instruction on a start request, decodes it, and drives the register-file, pipeline-register, operand-mux and ALU controls cycle by cycle. It signals idle/ready on `w`. It sits between the instruction source (switches or fetch unit) and the datapath.

Parameters:
- OPC_MOV, 3'b110, opcode value for the MOV class
- OPC_ALU, 3'b101, opcode value for the ALU class (ADD/CMP/AND/MVN)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  request to execute `in`; sampled only in WAIT
- in  input  16  instruction word
- w  output  1  high while in WAIT (ready for start)
- nsel  output  3  one-hot register select: 001=Rn, 010=Rd, 100=Rm, 000=none
- loada / loadb / loadc / loads  output  1 each  register load strobes
- asel  output  1  1 = force A operand to 0
- bsel  output  1  1 = B operand is sximm5 (always 0 in this block)
- vsel  output  2  write-back select: 00=C, 10=sximm8
- write  output  1  register-file write enable
- ALUop  output  2  IR[12:11] (00 add, 01 sub, 10 and, 11 not-B); forced 00 for MOV-reg
- shift  output  2  IR[4:3]; forced 00 in MOV-imm
- sximm8  output  16  IR[7:0], sign-extended
- illegal  output  1  see Optional Feature

Behaviour:
- IR is 16 bits. It loads `in` on the edge where state==WAIT and start==1, and holds otherwise.
- Fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
- States: WAIT, DECODE, GET_A, GET_B, EXEC, CMP, WR_IMM, WR_REG, HALT.
- All strobes are Moore outputs decoded from the state register. In every state, every strobe not listed below is 0.
- WAIT: w=1, all strobes 0. If start=1, go to DECODE; else stay.
- DECODE: no strobes. Next state:
  - MOV op=10 → WR_IMM
  - MOV op=00 → GET_B
  - ALU op=11 (MVN) → GET_B
  - ALU op=00/01/10 → GET_A
  - anything else → undefined path (Optional Feature)
- GET_A: nsel=001, loada=1 → GET_B.
- GET_B: nsel=100, loadb=1.
  - CMP → CMP
  - all others → EXEC
- EXEC: loadc=1. For MOV-reg: asel=1 and ALUop=00. Next state WR_REG.
- CMP: loads=1, loadc=0 → WAIT. No register write.
- WR_IMM: nsel=001, vsel=10, write=1 → WAIT.
- WR_REG: nsel=010, vsel=00, write=1 → WAIT.
- Latency from the start edge back to w=1:
  - MOV-imm: 3 cycles
  - MOV-reg / MVN: 5 cycles
  - CMP: 5 cycles
  - ADD / AND: 6 cycles
- `start` held high re-triggers on the first WAIT cycle. Starts outside WAIT are ignored and IR is unchanged.
- Reset, including mid-instruction: on the next edge state=WAIT, IR=0, illegal=0. All strobes go to 0 that cycle; w=1 the cycle after the reset edge.
- No partial write-back is ever issued after reset.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode/op in DECODE goes to HALT. HALT asserts illegal=1, w=0, all strobes 0, ignores start, and exits only on reset.
- Undefined: an undefined encoding goes DECODE → WAIT as a NOP (2 cycles). illegal is tied to 0.

Test Plan:
- MOV R0,#7: reset, then start with in=16'hD007 → WR_IMM cycle shows write=1, nsel=001, vsel=10, sximm8=16'h0007; w=1 three cycles after start.
- MOV R1,#-2: in=16'hD1FE → sximm8=16'hFFFE during WR_IMM.
- ADD R2,R1,R0: in=16'hA140 → loada(nsel=001), then loadb(nsel=100), then loadc with ALUop=00, then write with nsel=010/vsel=00; 6 cycles total.
- CMP R1,R0 LSL#1: in=16'hA908 → shift=01, ALUop=01, loads=1, loadc=0, no write; w returns after 5 cycles.
- MVN R3,R1: in=16'hB861 → no loada; ALUop=11; write with nsel=010. Then assert reset during EXEC of a second MVN → no write strobe occurs, w=1 the next cycle.
- Illegal in=16'hE000: with CTRL_ILLEGAL_TRAP_EN, illegal=1 and stuck until reset; without it, w=1 two cycles after start and no strobes fire.

Source files
------------

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: Moore sequencer for the 16-bit register-file/shifter/ALU
// datapath. It latches one instruction per start request, decodes it, then
// walks the datapath through operand fetch, execute and write-back. It
// raises w while idle and ready for a new start.
//
// Optional build macro: CTRL_ILLEGAL_TRAP_EN
//   defined   - an undefined encoding traps into HALT (illegal=1) until reset
//   undefined - an undefined encoding retires as a two-cycle NOP, illegal=0
module datapath_ctrl #(
    parameter logic [2:0] OPC_MOV = 3'b110,
    parameter logic [2:0] OPC_ALU = 3'b101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  nsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic        write,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_CMP,
        S_WR_IMM,
        S_WR_REG,
        S_HALT
    } state_t;

    // one-hot register selects driven onto nsel
    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_RN   = 3'b001;
    localparam logic [2:0] SEL_RD   = 3'b010;
    localparam logic [2:0] SEL_RM   = 3'b100;

    // write-back source selects driven onto vsel
    localparam logic [1:0] VSEL_C      = 2'b00;
    localparam logic [1:0] VSEL_SXIMM8 = 2'b10;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] ir_q;

    // instruction fields
    logic [2:0] opcode;
    logic [1:0] op;
    logic       is_mov;
    logic       is_alu;
    logic       mov_imm;
    logic       mov_reg;
    logic       alu_mvn;
    logic       alu_cmp;
    logic       enc_legal;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];

    assign is_mov    = (opcode == OPC_MOV);
    assign is_alu    = (opcode == OPC_ALU);
    assign mov_imm   = is_mov && (op == 2'b10);
    assign mov_reg   = is_mov && (op == 2'b00);
    assign alu_mvn   = is_alu && (op == 2'b11);
    assign alu_cmp   = is_alu && (op == 2'b01);
    assign enc_legal = mov_imm || mov_reg || is_alu;

    // Rn/Rd/Rm are routed by the datapath itself via nsel; the controller
    // never needs the Rn bits, so fold them away explicitly.
    logic unused_rn;
    assign unused_rn = ^ir_q[10:8];

    // State register and instruction register; IR only captures in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (state_q == S_WAIT && start) begin
                ir_q <= in;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (start) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (mov_imm) begin
                    state_d = S_WR_IMM;
                end else if (mov_reg || alu_mvn) begin
                    state_d = S_GET_B;
                end else if (is_alu) begin
                    state_d = S_GET_A;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = alu_cmp ? S_CMP : S_EXEC;
            S_EXEC:   state_d = S_WR_REG;
            S_CMP:    state_d = S_WAIT;
            S_WR_IMM: state_d = S_WAIT;
            S_WR_REG: state_d = S_WAIT;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_WAIT;
        endcase
    end

    // Moore strobes: a pure function of the state register.
    always_comb begin
        w     = 1'b0;
        nsel  = SEL_NONE;
        loada = 1'b0;
        loadb = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        vsel  = VSEL_C;
        write = 1'b0;
        case (state_q)
            S_WAIT: begin
                w = 1'b1;
            end
            S_GET_A: begin
                nsel  = SEL_RN;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = SEL_RM;
                loadb = 1'b1;
            end
            S_EXEC: begin
                loadc = 1'b1;
                // MOV Rd,Rm is computed as 0 + shifted Rm
                asel  = mov_reg;
            end
            S_CMP: begin
                loads = 1'b1;
            end
            S_WR_IMM: begin
                nsel  = SEL_RN;
                vsel  = VSEL_SXIMM8;
                write = 1'b1;
            end
            S_WR_REG: begin
                nsel  = SEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            default: begin
                w = 1'b0;
            end
        endcase
    end

    // Field-derived controls follow IR directly; the strobes decide
    // whether the datapath actually uses them in a given cycle.
    assign ALUop  = mov_reg ? 2'b00 : op;
    assign shift  = mov_imm ? 2'b00 : ir_q[4:3];
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_HALT);
`else
    assign illegal = 1'b0;
`endif

    // enc_legal documents the decode partition; HALT/NOP takes the rest
    logic unused_legal;
    assign unused_legal = enc_legal;

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: scoreboard bench for datapath_ctrl. Each instruction
// pushes its expected per-cycle control vector trace into a queue; the trace
// is popped and compared one entry per clock while the DUT runs.
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] instr_in;
    logic        w;
    logic [2:0]  nsel;
    logic        loada, loadb, loadc, loads, asel, bsel, write, illegal;
    logic [1:0]  vsel, ALUop, shift;
    logic [15:0] sximm8;

    datapath_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .in(instr_in),
        .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel), .write(write),
        .ALUop(ALUop), .shift(shift), .sximm8(sximm8), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef logic [33:0] vec_t;

    int   errors = 0;
    int   checks = 0;
    vec_t exp_q[$];

    function automatic vec_t observed();
        return {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write,
                ALUop, shift, illegal, sximm8};
    endfunction

    // Expected vector for one cycle: strobes given, IR-derived fields from ir.
    function automatic vec_t mk(input logic ww, input logic [2:0] ns,
                                input logic la, input logic lb, input logic lc,
                                input logic ls, input logic as,
                                input logic [1:0] vs, input logic wr,
                                input logic ill, input logic [15:0] ir);
        logic [1:0] alu;
        logic [1:0] sh;
        alu = (ir[15:13] == 3'b110 && ir[12:11] == 2'b00) ? 2'b00 : ir[12:11];
        sh  = (ir[15:13] == 3'b110 && ir[12:11] == 2'b10) ? 2'b00 : ir[4:3];
        return {ww, ns, la, lb, lc, ls, as, 1'b0, vs, wr, alu, sh, ill,
                {{8{ir[7]}}, ir[7:0]}};
    endfunction

    task automatic check_eq(input string tag, input vec_t obs, input vec_t exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Push the full expected trace (start edge through return to WAIT).
    task automatic push_instr(input logic [15:0] ir, output int lat);
        logic [2:0] opc;
        logic [1:0] op;
        opc = ir[15:13];
        op  = ir[12:11];
        exp_q.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, ir)); // DECODE
        if (opc == 3'b110 && op == 2'b10) begin
            exp_q.push_back(mk(0, 3'b001, 0, 0, 0, 0, 0, 2'b10, 1, 0, ir));
            lat = 3;
        end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
            exp_q.push_back(mk(0, 3'b100, 0, 1, 0, 0, 0, 2'b00, 0, 0, ir));
            exp_q.push_back(mk(0, 3'b000, 0, 0, 1, 0, (opc == 3'b110), 2'b00, 0, 0, ir));
            exp_q.push_back(mk(0, 3'b010, 0, 0, 0, 0, 0, 2'b00, 1, 0, ir));
            lat = 5;
        end else if (opc == 3'b101 && op == 2'b01) begin
            exp_q.push_back(mk(0, 3'b001, 1, 0, 0, 0, 0, 2'b00, 0, 0, ir));
            exp_q.push_back(mk(0, 3'b100, 0, 1, 0, 0, 0, 2'b00, 0, 0, ir));
            exp_q.push_back(mk(0, 3'b000, 0, 0, 0, 1, 0, 2'b00, 0, 0, ir));
            lat = 5;
        end else if (opc == 3'b101) begin
            exp_q.push_back(mk(0, 3'b001, 1, 0, 0, 0, 0, 2'b00, 0, 0, ir));
            exp_q.push_back(mk(0, 3'b100, 0, 1, 0, 0, 0, 2'b00, 0, 0, ir));
            exp_q.push_back(mk(0, 3'b000, 0, 0, 1, 0, 0, 2'b00, 0, 0, ir));
            exp_q.push_back(mk(0, 3'b010, 0, 0, 0, 0, 0, 2'b00, 1, 0, ir));
            lat = 6;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            for (int i = 0; i < 4; i++)
                exp_q.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 1, ir));
            lat = 99;
            return;
`else
            lat = 2;
`endif
        end
        exp_q.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, ir)); // WAIT
    endtask

    // reps>1 holds start high so the instruction re-triggers from WAIT;
    // noise pulses start with random words while busy; reset_at>0 resets
    // after that many cycles and checks the idle state that follows.
    task automatic run(input logic [15:0] ir, input int reps, input bit noise,
                       input int reset_at);
        int   lat;
        int   n;
        vec_t idle_v;
        @(negedge clk);
        instr_in = ir;
        start    = 1'b1;
        for (int r = 0; r < reps; r++) push_instr(ir, lat);
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            n++;
            check_eq($sformatf("%h c%0d", ir, n), observed(), exp_q.pop_front());
            if (reset_at == n) begin
                reset = 1'b1;
                start = 1'b0;
                exp_q.delete();
                @(negedge clk);
                idle_v = mk(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 16'h0000);
                check_eq($sformatf("%h rst", ir), observed(), idle_v);
                reset = 1'b0;
                @(negedge clk);
                check_eq($sformatf("%h rst+1", ir), observed(), idle_v);
                break;
            end
            if (noise && exp_q.size() > 0) begin
                start    = 1'b1;
                instr_in = 16'($urandom);
            end else if (exp_q.size() < lat) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        $display("instr %h reps=%0d noise=%0d reset_at=%0d cycles=%0d errors=%0d",
                 ir, reps, noise, reset_at, n, errors);
    endtask

    initial begin
        vec_t idle0;
        reset    = 1'b1;
        start    = 1'b0;
        instr_in = 16'h0000;
        idle0    = mk(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 16'h0000);
        repeat (2) @(negedge clk);
        check_eq("reset", observed(), idle0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle", observed(), idle0);

        run(16'hD007, 1, 0, 0);   // MOV R0,#7
        run(16'hD1FE, 1, 0, 0);   // MOV R1,#-2
        run(16'hA140, 1, 0, 0);   // ADD R2,R1,R0
        run(16'hA908, 1, 0, 0);   // CMP R1,R0 LSL#1
        run(16'hB861, 1, 0, 0);   // MVN R3,R1
        run(16'hB8A2, 1, 0, 3);   // MVN R5,R2, reset during EXEC
        run(16'hB140, 1, 1, 0);   // AND R2,R1,R0 with starts while busy
        run(16'hC069, 1, 1, 0);   // MOV R3,R1 LSL#1 with starts while busy
        run(16'hD0FF, 2, 0, 0);   // MOV R0,#-1 with start held high
        run(16'hE000, 1, 1, 0);   // undefined opcode
`ifdef CTRL_ILLEGAL_TRAP_EN
        reset = 1'b1;
        @(negedge clk);
        check_eq("halt reset", observed(), idle0);
        reset = 1'b0;
`endif
        run(16'hA140, 1, 0, 0);   // still operational afterwards

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
